// File: rtl/control_pkg.sv
// Shared opcode, ALU-code and state definitions for the multicycle control unit.
package control_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_TRAP
  } state_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: instruction class, legality and ALU operation.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] op_q,
  output logic                is_rtype,
  output logic                is_lw,
  output logic                is_sw,
  output logic                is_bne,
  output logic                legal,
  output logic [ALUOP_W-1:0]  alu_op
);

  logic       hi_zero;
  logic [3:0] op_lo;
  logic [2:0] code;

  assign op_lo   = op_q[3:0];
  // Any set bit above the 4-bit opcode field makes the instruction illegal.
  assign hi_zero = ((op_q >> 4) == '0);

  always_comb begin
    is_rtype = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_bne   = 1'b0;
    legal    = 1'b0;
    code     = ALU_AND;
    alu_op   = '0;
    case (op_lo)
      OP_AND: begin is_rtype = 1'b1; code = ALU_AND; end
      OP_OR:  begin is_rtype = 1'b1; code = ALU_OR;  end
      OP_ADD: begin is_rtype = 1'b1; code = ALU_ADD; end
      OP_SUB: begin is_rtype = 1'b1; code = ALU_SUB; end
      OP_SLT: begin is_rtype = 1'b1; code = ALU_SLT; end
      OP_LW:  begin is_lw    = 1'b1; code = ALU_ADD; end
      OP_SW:  begin is_sw    = 1'b1; code = ALU_ADD; end
      OP_BNE: begin is_bne   = 1'b1; code = ALU_SUB; end
      default: ;
    endcase
    if (!hi_zero) begin
      is_rtype = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_bne   = 1'b0;
    end
    legal = is_rtype | is_lw | is_sw | is_bne;
    if (legal) alu_op = ALUOP_W'(code);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a sticky
// illegal-opcode trap and a retired-instruction counter.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal,
  output logic                done,
  output logic [CNT_W-1:0]    instr_count
);

  state_t              state;
  state_t              state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] op_sel;
  logic [CNT_W-1:0]    cnt_q;

  logic                is_rtype;
  logic                is_lw;
  logic                is_sw;
  logic                is_bne;
  logic                legal;
  logic [ALUOP_W-1:0]  dec_alu_op;

  // DECODE classifies the live opcode (op_q is loaded at the end of that cycle);
  // every later state uses only the latched copy.
  assign op_sel = (state == S_DECODE) ? opcode : op_q;

  control_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .op_q     (op_sel),
    .is_rtype (is_rtype),
    .is_lw    (is_lw),
    .is_sw    (is_sw),
    .is_bne   (is_bne),
    .legal    (legal),
    .alu_op   (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= opcode;
      if (done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Outputs are held at zero throughout reset, including the first reset cycle.
  assign instr_count = rst ? '0 : cnt_q;

  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = '0;
    illegal    = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: state_nx = legal ? S_EXECUTE : S_TRAP;
        S_EXECUTE: begin
          alu_op  = dec_alu_op;
          alu_src = is_lw | is_sw;
          if (is_bne) begin
            pc_write = !zero;
            pc_src   = !zero;
            done     = 1'b1;
            state_nx = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_nx = S_MEMORY;
          end else begin
            state_nx = S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
          alu_op  = dec_alu_op;
          alu_src = 1'b1;
          if (mem_ready) begin
            done     = is_sw;
            state_nx = is_sw ? S_FETCH : S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_lw;
          alu_op     = dec_alu_op;
          alu_src    = is_lw;
          done       = 1'b1;
          state_nx   = S_FETCH;
        end
        S_TRAP: illegal = 1'b1;
        default: state_nx = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed latency table, corner-case sequences and
// randomized instructions checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;

  localparam int OPCODE_W = 4;
  localparam int ALUOP_W  = 3;
  localparam int CNT_W    = 2;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [OPCODE_W-1:0] opcode = '0;
  logic                zero = 1'b0;
  logic                mem_ready = 1'b0;
  logic                mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic                reg_dst, reg_write, alu_src, mem_to_reg, illegal, done;
  logic [ALUOP_W-1:0]  alu_op;
  logic [CNT_W-1:0]    instr_count;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .done        (done),
    .instr_count (instr_count)
  );

  // Output bundle: {req,we,iord,irw,pcw,pcs,rdst,rw,asrc,m2r,aluop[2:0],ill,done}
  logic [14:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_dst,
                reg_write, alu_src, mem_to_reg, alu_op, illegal, done};

  typedef struct {
    logic        rdy;
    logic        z;
    logic [3:0]  opc;
    logic [14:0] exp;
  } cyc_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         cycles;
  } vec_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic logic [14:0] ov(input logic req, we, io, irw, pcw, pcs, rd, rw,
                                     as, m2r, input logic [2:0] aop, input logic ill, dn);
    return {req, we, io, irw, pcw, pcs, rd, rw, as, m2r, aop, ill, dn};
  endfunction

  // Instruction class: 0 R-type, 1 LW, 2 SW, 3 BNE, 4 illegal.
  function automatic int cls(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: return 0;
      4'b1000: return 1;
      4'b1010: return 2;
      4'b1110: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] aluof(input logic [3:0] op);
    case (op)
      4'b0000: return 3'b000;
      4'b0001: return 3'b001;
      4'b0010, 4'b1000, 4'b1010: return 3'b010;
      4'b0110, 4'b1110: return 3'b011;
      4'b0111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic r, input logic z, input logic [3:0] o, input logic [14:0] e);
    cyc_t c;
    c.rdy = r; c.z = z; c.opc = o; c.exp = e;
    q.push_back(c);
  endtask

  // Expected per-cycle behaviour of one instruction, from the ISA description.
  task automatic build(input logic [3:0] op, input logic z, input int fw, input int mw);
    int         k;
    logic [2:0] a;
    logic       ls;
    k  = cls(op);
    a  = aluof(op);
    ls = (k == 1) || (k == 2);
    q.delete();
    for (int i = 0; i < fw; i++) push(1'b0, rb(), rop(), ov(1,0,0,0,0,0,0,0,0,0,3'b0,0,0));
    push(1'b1, rb(), rop(), ov(1,0,0,1,1,0,0,0,0,0,3'b0,0,0));
    push(rb(), rb(), op, 15'b0);
    if (k == 4) begin
      for (int i = 0; i < 20; i++) push(rb(), rb(), rop(), ov(0,0,0,0,0,0,0,0,0,0,3'b0,1,0));
    end else begin
      if (k == 3) push(rb(), z, rop(), ov(0,0,0,0,!z,!z,0,0,0,0,a,0,1));
      else        push(rb(), rb(), rop(), ov(0,0,0,0,0,0,0,0,ls,0,a,0,0));
      if (ls) begin
        for (int i = 0; i < mw; i++) push(1'b0, rb(), rop(), ov(1,k==2,1,0,0,0,0,0,1,0,a,0,0));
        push(1'b1, rb(), rop(), ov(1,k==2,1,0,0,0,0,0,1,0,a,0,k==2));
      end
      if (k == 0 || k == 1) push(rb(), rb(), rop(), ov(0,0,0,0,0,0,k==0,1,ls,k==1,a,0,1));
    end
  endtask

  // Applies up to lim queued cycles; entered and left at 1 time unit after posedge.
  task automatic run(input string nm, input int lim, output int done_at);
    done_at = -1;
    for (int i = 0; i < q.size() && i < lim; i++) begin
      opcode = q[i].opc; zero = q[i].z; mem_ready = q[i].rdy;
      @(negedge clk);
      chk($sformatf("%s_c%0d_out", nm, i), 32'(act), 32'(q[i].exp));
      chk($sformatf("%s_c%0d_cnt", nm, i), 32'(instr_count), 32'(mcnt));
      if (done === 1'b1 && done_at < 0) done_at = i;
      @(posedge clk);
      if (q[i].exp[0]) mcnt = (mcnt + 1) % CNT_MOD;
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = rb(); zero = rb(); opcode = rop();
      @(negedge clk);
      chk("rst_out", 32'(act), 32'd0);
      chk("rst_cnt", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    mcnt = 0;
  endtask

  vec_t       tbl[11];
  logic [3:0] legal_ops[8];
  int         wrap_seq[5];
  int         da;

  initial begin
    tbl[0]  = '{"add",    4'b0010, 1'b0, 0, 0, 4};
    tbl[1]  = '{"lw_w2",  4'b1000, 1'b0, 0, 2, 7};
    tbl[2]  = '{"sw",     4'b1010, 1'b0, 0, 0, 4};
    tbl[3]  = '{"bne_z0", 4'b1110, 1'b0, 0, 0, 3};
    tbl[4]  = '{"bne_z1", 4'b1110, 1'b1, 0, 0, 3};
    tbl[5]  = '{"and",    4'b0000, 1'b0, 0, 0, 4};
    tbl[6]  = '{"or",     4'b0001, 1'b1, 0, 0, 4};
    tbl[7]  = '{"sub",    4'b0110, 1'b0, 0, 0, 4};
    tbl[8]  = '{"slt",    4'b0111, 1'b0, 2, 0, 6};
    tbl[9]  = '{"lw",     4'b1000, 1'b0, 1, 0, 6};
    tbl[10] = '{"sw_w3",  4'b1010, 1'b0, 0, 3, 7};
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1110};
    wrap_seq  = '{1, 2, 3, 0, 1};

    do_reset(3);

    foreach (tbl[i]) begin
      build(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw);
      run(tbl[i].name, 1000, da);
      chk({tbl[i].name, "_latency"}, 32'(da + 1), 32'(tbl[i].cycles));
      if (i == 0) chk("add_count", 32'(instr_count), 32'd1);
    end

    // Reset during a fetch wait: no retirement, counter cleared.
    build(4'b0010, 1'b0, 5, 0);
    run("rst_fetch", 3, da);
    do_reset(2);
    chk("rst_fetch_done", 32'(da), 32'hffff_ffff);
    build(4'b0010, 1'b0, 0, 0);
    run("post_rst", 1000, da);
    chk("post_rst_count", 32'(instr_count), 32'd1);

    // Reset while a load is waiting in MEMORY.
    build(4'b1000, 1'b0, 0, 4);
    run("rst_mem", 5, da);
    do_reset(1);
    chk("rst_mem_done", 32'(da), 32'hffff_ffff);

    // Illegal opcode traps for good until reset.
    build(4'b0011, 1'b0, 1, 0);
    run("trap", 1000, da);
    chk("trap_nodone", 32'(da), 32'hffff_ffff);
    do_reset(2);

    // Counter wrap with a 2-bit counter.
    for (int j = 0; j < 5; j++) begin
      build(legal_ops[$urandom_range(0, 7)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      run("wrap", 1000, da);
      chk($sformatf("wrap_%0d", j), 32'(instr_count), 32'(wrap_seq[j]));
    end

    // Randomized legal instructions with random wait states.
    for (int j = 0; j < 60; j++) begin
      build(legal_ops[$urandom_range(0, 7)], rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      run($sformatf("rnd%0d", j), 1000, da);
      chk($sformatf("rnd%0d_latency", j), 32'(da + 1), 32'(q.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
